// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath (slave).
// The datapath supplies instruction fields and the ALU zero flag; the controller drives every select/enable.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 pc_en;
  logic                 iord;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           pc_src;
  logic [1:0]           alu_op_sel;
  logic [3:0]           state;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_op_sel, state, illegal, retired
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_op_sel, state, illegal, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the shared-ALU MIPS datapath through fetch/decode/execute/memory/writeback,
// plus a retired-instruction counter and a one-cycle pulse for unsupported encodings.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mips_multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  state_e                state_q, state_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  retire_c;

  logic       pc_en_c, iord_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_src_c, alu_op_sel_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    illegal_d    = 1'b0;
    retire_c     = 1'b0;
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_src_c     = 2'b00;
    alu_op_sel_c = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_en_c     = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // The ALU is otherwise idle here, so precompute the branch target.
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
      end
      S_MEMWRITE: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        state_d     = S_ALUWB;
        case (bus.funct)
          FN_ADD: alu_op_sel_c = ALU_ADD;
          FN_OR:  alu_op_sel_c = ALU_OR;
          FN_SUB: alu_op_sel_c = ALU_SUB;
          FN_SLT: alu_op_sel_c = ALU_SLT;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alu_op_sel_c = ALU_SUB;
        pc_src_c     = 2'b01;
        pc_en_c      = bus.zero;
        retire_c     = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_JUMP: begin
        pc_src_c = 2'b10;
        pc_en_c  = 1'b1;
        retire_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + CNT_WIDTH'(retire_c);
  end

  // Architectural write enables must stay quiet while reset is held, even though state reads FETCH.
  assign bus.pc_en      = pc_en_c & rst_n;
  assign bus.ir_write   = ir_write_c & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.iord       = iord_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_op_sel = alu_op_sel_c;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model expands each instruction into its
// expected per-cycle state/control/illegal/retired record; a compare process checks every cycle.
module tb_mips_multicycle_ctrl;
  localparam int W = 4;

  typedef struct packed {
    logic [3:0]   st;
    logic [13:0]  ctrl;
    logic         ill;
    logic [W-1:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_WIDTH(W)) bus ();
  mips_multicycle_ctrl #(.CNT_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t         exp_q[$];
  exp_t         cur;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_ret  = '0;
  logic         pend_ill = 1'b0;
  logic [5:0]   legal_fn[4] = '{6'h20, 6'h25, 6'h22, 6'h2A};

  // Control vector order: pc_en iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
  // alu_src_b[1:0] pc_src[1:0] alu_op_sel[1:0]
  function automatic logic [13:0] pk(bit pe, bit io, bit mw, bit iw, bit rd, bit mr, bit rw,
                                     bit sa, logic [1:0] sb, logic [1:0] ps, logic [1:0] op);
    return {pe, io, mw, iw, rd, mr, rw, sa, sb, ps, op};
  endfunction

  function automatic logic [13:0] exp_ctrl(int st, logic [5:0] fn, logic z);
    logic [1:0] op_r;
    case (fn)
      6'h20:   op_r = 2'b00;
      6'h25:   op_r = 2'b01;
      6'h22:   op_r = 2'b10;
      6'h2A:   op_r = 2'b11;
      default: op_r = 2'b00;
    endcase
    case (st)
      0:       return pk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      1:       return pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      2:       return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      3:       return pk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      4:       return pk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      5:       return pk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      6:       return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, op_r);
      7:       return pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      8:       return pk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b10);
      9:       return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      10:      return pk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      11:      return pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00);
      default: return '0;
    endcase
  endfunction

  function automatic bit fn_ok(logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h25 || fn == 6'h22 || fn == 6'h2A;
  endfunction

  function automatic bit op_ok(logic [5:0] op);
    return op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  // Expands one instruction into its cycle path and drives it; zmode 0/1 forces zero, 2 randomises.
  // max_cycles < path length truncates the instruction and leaves time just after that cycle's check.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int max_cycles);
    int   path[$];
    bit   legal;
    exp_t e;
    legal = 1'b1;
    case (op)
      6'h23: path = {0, 1, 2, 3, 4};
      6'h2B: path = {0, 1, 2, 5};
      6'h00: begin
        if (fn_ok(fn)) path = {0, 1, 6, 7};
        else begin path = {0, 1, 6}; legal = 1'b0; end
      end
      6'h04: path = {0, 1, 8};
      6'h08: path = {0, 1, 9, 10};
      6'h02: path = {0, 1, 11};
      default: begin path = {0, 1}; legal = 1'b0; end
    endcase
    foreach (path[i]) begin
      if (i >= max_cycles) return;
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      e.st   = 4'(path[i]);
      e.ctrl = exp_ctrl(path[i], fn, bus.zero);
      e.ill  = (i == 0) ? pend_ill : 1'b0;
      e.ret  = m_ret;
      exp_q.push_back(e);
      if (i == max_cycles - 1) begin
        @(negedge clk); #1;
        return;
      end
      @(posedge clk); #2;
    end
    pend_ill = !legal;
    if (legal) m_ret = m_ret + 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ret = '0;
    pend_ill = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_illegal", 32'(bus.illegal), 32'd0);
    check("reset_retired", 32'(bus.retired), 32'd0);
    check("reset_enables", 32'({bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    int k;
    k  = $urandom_range(0, 9);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0: op = 6'h23;
      1: op = 6'h2B;
      2, 3: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 3)]; end
      4: begin
        op = 6'h00;
        while (fn_ok(fn)) fn = 6'($urandom_range(0, 63));
      end
      5: op = 6'h04;
      6, 9: op = 6'h08;
      7: op = 6'h02;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op_ok(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    run_instr(op, fn, 2, 99);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        checks++;
        if ({bus.state,
             bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_op_sel,
             bus.illegal, bus.retired} !== cur) begin
          errors++;
          $display("FAIL cycle: got state=%0d ctrl=%b ill=%b ret=%0d expected state=%0d ctrl=%b ill=%b ret=%0d at %0t",
                   bus.state,
                   {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                    bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_op_sel},
                   bus.illegal, bus.retired, cur.st, cur.ctrl, cur.ill, cur.ret, $time);
        end
      end
    end
  end

  initial begin
    bus.opcode = '0;
    bus.funct  = '0;
    bus.zero   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    do_reset();

    run_instr(6'h00, 6'h20, 2, 99);
    check("add_retired", 32'(bus.retired), 32'd1);
    run_instr(6'h23, 6'h00, 2, 99);
    run_instr(6'h2B, 6'h00, 2, 99);
    check("lw_sw_retired", 32'(bus.retired), 32'd3);
    run_instr(6'h04, 6'h00, 1, 99);
    run_instr(6'h04, 6'h00, 0, 99);
    check("beq_retired", 32'(bus.retired), 32'd5);
    run_instr(6'h3F, 6'h00, 2, 99);
    check("bad_op_illegal", 32'(bus.illegal), 32'd1);
    check("bad_op_retired", 32'(bus.retired), 32'd5);
    run_instr(6'h00, 6'h00, 2, 99);
    check("bad_fn_illegal", 32'(bus.illegal), 32'd1);
    check("bad_fn_retired", 32'(bus.retired), 32'd5);

    repeat (150) run_random();

    // Interrupt a lw while it sits in MEMREAD.
    run_instr(6'h23, 6'h00, 2, 4);
    rst_n = 1'b0;
    #1;
    check("midreset_state", 32'(bus.state), 32'd0);
    check("midreset_enables", 32'({bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write}), 32'd0);
    check("midreset_retired", 32'(bus.retired), 32'd0);
    check("midreset_illegal", 32'(bus.illegal), 32'd0);
    do_reset();

    repeat (15) run_instr(6'h02, 6'h00, 2, 99);
    check("count_15", 32'(bus.retired), 32'd15);
    run_instr(6'h02, 6'h00, 2, 99);
    check("count_wrap", 32'(bus.retired), 32'd0);
    run_instr(6'h08, 6'h00, 2, 99);

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
